// File: rtl/adam_periph_uart_tx_buf_if.sv
// ---------------------------------------------------------------------------
// adam_periph_uart_tx_buf_if
// Character stream between the UART register file (master) and the buffered
// transmitter (slave).
//   valid : master has a character on data
//   ready : slave can accept the character this cycle
//   data  : character; the transmitter uses bits [8:0]
// ---------------------------------------------------------------------------
interface adam_periph_uart_tx_buf_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/adam_periph_uart_tx_buf.sv
// ---------------------------------------------------------------------------
// adam_periph_uart_tx_buf
// Buffered UART transmitter: a FIFO of FIFO_DEPTH characters feeding a frame
// serialiser (start, LSB-first data, optional parity, 1 or 2 stop bits), with
// line-break generation and a pause req/ack window for configuration changes.
//   clk, rst_n        : clock, asynchronous active-low reset
//   pause_req/ack     : configuration may change while both are high
//   parity_*          : parity enable, odd/even (or stick value), stick mode
//   data_length       : data bits per frame, clamped to 1..9
//   stop_bits         : 0 = one stop bit, 1 = two
//   baud_rate         : bit period minus one, in clk cycles
//   break_req         : hold tx low (at least one frame time)
//   slv               : character stream in
//   tx                : registered serial output
//   fifo_level/empty  : FIFO status for interrupt logic
//   busy              : serialiser not idle
// ---------------------------------------------------------------------------
module adam_periph_uart_tx_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pause_req,
    output logic                    pause_ack,
    input  logic                    parity_control,
    input  logic                    parity_select,
    input  logic                    parity_stick,
    input  logic [3:0]              data_length,
    input  logic                    stop_bits,
    input  logic [DATA_WIDTH-1:0]   baud_rate,
    input  logic                    break_req,
    adam_periph_uart_tx_buf_if.slave slv,
    output logic                    tx,
    output logic [LVL_W-1:0]        fifo_level,
    output logic                    fifo_empty,
    output logic                    busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_BREAK     = 3'd5;
    localparam logic [2:0] ST_BREAK_END = 3'd6;

    logic [8:0]            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  can_start;

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] clk_cnt;
    logic [3:0]            bit_cnt;
    logic [3:0]            eff_len;
    logic [3:0]            frame_bits;
    logic [8:0]            shift;
    logic                  parity_acc;
    logic                  bit_end;
    logic                  stop_done;
    logic                  break_done;
    logic                  tx_d;
    logic                  unused_data_hi;

    assign unused_data_hi = ^slv.data[DATA_WIDTH-1:9];

    assign full       = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign slv.ready  = !full && !pause_req && !pause_ack;
    assign push       = slv.valid && slv.ready;
    assign busy       = (state != ST_IDLE);

    // Clamp the data length to the supported 1..9 range.
    always_comb begin
        eff_len = data_length;
        if (data_length == 4'd0) begin
            eff_len = 4'd1;
        end else if (data_length > 4'd9) begin
            eff_len = 4'd9;
        end
    end

    // Break minimum length, in bits, is one full frame with the current config.
    assign frame_bits = 4'd2 + eff_len + {3'b000, parity_control} + {3'b000, stop_bits};

    // All counter tests use >= so a config change mid-frame cannot strand the FSM.
    assign bit_end    = (clk_cnt >= baud_rate);
    assign stop_done  = bit_end && (bit_cnt >= {3'b000, stop_bits});
    assign break_done = (bit_cnt >= frame_bits) ||
                        (bit_end && ((bit_cnt + 4'd1) >= frame_bits));

    // A new frame may start from IDLE or straight out of the last stop bit,
    // which is what makes back-to-back frames gap-free. A break request
    // always wins over a queued character.
    assign can_start = !fifo_empty && !pause_req && !pause_ack && !break_req;
    assign pop = can_start && ((state == ST_IDLE) || ((state == ST_STOP) && stop_done));

    // Line level for the current state; tx is this value delayed by one register.
    always_comb begin
        tx_d = 1'b1;
        case (state)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift[0];
            ST_PARITY: tx_d = parity_stick ? parity_select : (parity_acc ^ parity_select);
            ST_BREAK:  tx_d = 1'b0;
            default:   tx_d = 1'b1;
        endcase
    end

    // FIFO storage; contents need no reset because level/pointers gate them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= slv.data[8:0];
        end
    end

    // FIFO pointers and level; pointers wrap naturally (depth is a power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // Frame serialiser. pause_ack only tracks pause_req while idle, so any
    // frame or break in progress finishes before the pause is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_acc <= 1'b0;
            tx         <= 1'b1;
            pause_ack  <= 1'b1;
        end else begin
            tx <= tx_d;
            if (state == ST_IDLE) begin
                pause_ack <= pause_req;
            end
            case (state)
                ST_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (break_req && !pause_req && !pause_ack) begin
                        state <= ST_BREAK;
                    end else if (pop) begin
                        shift      <= mem[rd_ptr];
                        parity_acc <= 1'b0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        clk_cnt    <= '0;
                        shift      <= {1'b0, shift[8:1]};
                        parity_acc <= parity_acc ^ shift[0];
                        if ((bit_cnt + 4'd1) >= eff_len) begin
                            bit_cnt <= '0;
                            state   <= parity_control ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= ST_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (stop_done) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                shift      <= mem[rd_ptr];
                                parity_acc <= 1'b0;
                                state      <= ST_START;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Leave as soon as the minimum is met and the request is gone,
                    // not only on a bit boundary. bit_cnt saturates at frame_bits.
                    if (break_done && !break_req) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= ST_BREAK_END;
                    end else if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt < frame_bits) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_BREAK_END: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
